// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: four single-byte reads assemble one little-endian word.
// Optional 32-entry direct-mapped instruction cache under INST_FETCH_ICACHE_EN.
module inst_fetch (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        br_in,
  input  logic [31:0] br_target_in,
  input  logic        stall_in,
  input  logic        mem_busy_in,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a_out,
  output logic        mem_rd_out,
  output logic [31:0] if_inst_pc,
  output logic [31:0] if_inst,
  output logic        busy_out
);

  typedef enum logic [2:0] {F0, F1, F2, F3, R3, HOLD} state_t;

  state_t      state, state_eff, state_nxt;
  logic        rdy_q;
  logic [31:0] pc;
  logic [7:0]  b0, b1, b2;
  logic [31:0] buf_inst;
  logic [31:0] inst_asm;
  logic [31:0] present_inst;
  logic        present;
  logic        to_hold;
  logic        ic_hit;
  logic [31:0] ic_rdata;
  logic [1:0]  a_off;

  assign inst_asm = {mem_din, b2, b1, b0};

  // A byte requested just before a freeze is lost, so the fetch restarts from F0.
  always_comb begin
    state_eff = state;
    if (!rdy_q && (state == F1 || state == F2 || state == F3 || state == R3))
      state_eff = F0;
  end

`ifdef INST_FETCH_ICACHE_EN
  logic [31:0] ic_data [32];
  logic [24:0] ic_tag  [32];
  logic [31:0] ic_vld;
  logic [4:0]  ic_idx;
  logic        ic_fill;

  assign ic_idx   = pc[6:2];
  assign ic_hit   = ic_vld[ic_idx] && (ic_tag[ic_idx] == pc[31:7]);
  assign ic_rdata = ic_data[ic_idx];
  assign ic_fill  = rdy_in && !br_in && (state_eff == R3);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      ic_vld <= '0;
    else if (ic_fill)
      ic_vld[ic_idx] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (ic_fill) begin
      ic_data[ic_idx] <= inst_asm;
      ic_tag[ic_idx]  <= pc[31:7];
    end
  end
`else
  assign ic_hit   = 1'b0;
  assign ic_rdata = '0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= F0;
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in)
        state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_eff;
    present      = 1'b0;
    to_hold      = 1'b0;
    present_inst = inst_asm;
    if (br_in) begin
      state_nxt = F0;
    end else begin
      case (state_eff)
        F0: begin
          if (ic_hit) begin
            present_inst = ic_rdata;
            if (stall_in) begin
              to_hold   = 1'b1;
              state_nxt = HOLD;
            end else begin
              present   = 1'b1;
              state_nxt = F0;
            end
          end else if (mem_busy_in) begin
            state_nxt = F0;
          end else begin
            state_nxt = F1;
          end
        end
        F1: state_nxt = mem_busy_in ? F0 : F2;
        F2: state_nxt = mem_busy_in ? F0 : F3;
        F3: state_nxt = mem_busy_in ? F0 : R3;
        R3: begin
          if (stall_in) begin
            to_hold   = 1'b1;
            state_nxt = HOLD;
          end else begin
            present   = 1'b1;
            state_nxt = F0;
          end
        end
        HOLD: begin
          present_inst = buf_inst;
          if (!stall_in) begin
            present   = 1'b1;
            state_nxt = F0;
          end
        end
        default: state_nxt = F0;
      endcase
    end
  end

  always_comb begin
    a_off      = 2'd0;
    mem_rd_out = 1'b0;
    case (state_eff)
      F0: mem_rd_out = !ic_hit;
      F1: begin a_off = 2'd1; mem_rd_out = 1'b1; end
      F2: begin a_off = 2'd2; mem_rd_out = 1'b1; end
      F3: begin a_off = 2'd3; mem_rd_out = 1'b1; end
      default: mem_rd_out = 1'b0;
    endcase
    if (!rdy_in || br_in || mem_busy_in)
      mem_rd_out = 1'b0;
    mem_a_out = pc + {30'd0, a_off};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc         <= '0;
      b0         <= '0;
      b1         <= '0;
      b2         <= '0;
      buf_inst   <= '0;
      if_inst    <= '0;
      if_inst_pc <= '0;
      busy_out   <= 1'b1;
    end else if (rdy_in) begin
      busy_out <= !present;
      if (br_in) begin
        pc <= br_target_in & 32'hFFFF_FFFC;
      end else begin
        if (present) begin
          pc         <= pc + 32'd4;
          if_inst    <= present_inst;
          if_inst_pc <= pc;
        end
        if (to_hold)
          buf_inst <= present_inst;
        case (state_eff)
          F1: b0 <= mem_din;
          F2: b1 <= mem_din;
          F3: b2 <= mem_din;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table plus branch-loop and reset-mid-fetch sequences.
module tb_inst_fetch;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        br_in = 1'b0;
  logic [31:0] br_target_in = '0;
  logic        stall_in = 1'b0;
  logic        mem_busy_in = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [31:0] mem_a_out;
  logic        mem_rd_out;
  logic [31:0] if_inst_pc;
  logic [31:0] if_inst;
  logic        busy_out;

  int n_chk = 0;
  int n_pass = 0;

  inst_fetch dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .br_in(br_in),
    .br_target_in(br_target_in), .stall_in(stall_in), .mem_busy_in(mem_busy_in),
    .mem_din(mem_din), .mem_a_out(mem_a_out), .mem_rd_out(mem_rd_out),
    .if_inst_pc(if_inst_pc), .if_inst(if_inst), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h0000_0013;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // Synchronous byte memory: data valid the cycle after the strobe.
  always @(posedge clk_in)
    mem_din <= mem_rd_out ? byte_at(mem_a_out) : 8'hEE;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  task automatic measure(output int lat);
    bit done;
    done = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk_in);
      #1;
      if (!busy_out) begin
        lat = n;
        done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic        rdy, br;
    logic [31:0] tgt;
    logic        stall, mb, chk, rd;
    logic [31:0] a;
    logic        busy;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[46];

  function automatic vec_t r(input logic rdy, input logic br, input logic [31:0] tgt,
                             input logic stall, input logic mb, input logic chk, input logic rd,
                             input logic [31:0] a, input logic busy, input logic [31:0] ipc);
    vec_t v;
    v = '{rdy, br, tgt, stall, mb, chk, rd, a, busy, ipc};
    return v;
  endfunction

  task automatic run_pass(input int p);
    int          lat, exp_lat;
    logic        exp_rd;
`ifdef INST_FETCH_ICACHE_EN
    exp_lat = (p == 2) ? 1 : 5;
`else
    exp_lat = 5;
`endif
    exp_rd = (exp_lat == 5);
    br_in = 1'b1;
    br_target_in = 32'h40;
    @(negedge clk_in);
    br_in = 1'b0;
    #1;
    chk32($sformatf("loop%0d_a40", p), mem_a_out, 32'h40);
    chk1($sformatf("loop%0d_rd40", p), mem_rd_out, exp_rd);
    measure(lat);
    chk32($sformatf("loop%0d_lat40", p), lat, exp_lat);
    chk32($sformatf("loop%0d_pc40", p), if_inst_pc, 32'h40);
    chk32($sformatf("loop%0d_inst40", p), if_inst, word_at(32'h40));
    chk1($sformatf("loop%0d_rd44", p), mem_rd_out, exp_rd);
    measure(lat);
    chk32($sformatf("loop%0d_lat44", p), lat, exp_lat);
    chk32($sformatf("loop%0d_pc44", p), if_inst_pc, 32'h44);
    chk32($sformatf("loop%0d_inst44", p), if_inst, word_at(32'h44));
  endtask

  initial begin
    int lat;
    // rdy, br, tgt, stall, mb, chk, rd, addr, busy, if_inst_pc
    vecs[0]  = r(1,0,0,0,0,1,1,32'h0,1,32'h0);
    vecs[1]  = r(1,0,0,0,0,1,1,32'h1,1,32'h0);
    vecs[2]  = r(1,0,0,0,0,1,1,32'h2,1,32'h0);
    vecs[3]  = r(1,0,0,0,0,1,1,32'h3,1,32'h0);
    vecs[4]  = r(1,0,0,0,0,1,0,32'h0,1,32'h0);
    vecs[5]  = r(1,0,0,0,0,1,1,32'h4,0,32'h0);
    vecs[6]  = r(1,0,0,0,0,1,1,32'h5,1,32'h0);
    vecs[7]  = r(1,0,0,0,0,1,1,32'h6,1,32'h0);
    vecs[8]  = r(1,0,0,0,0,1,1,32'h7,1,32'h0);
    vecs[9]  = r(1,0,0,0,0,1,0,32'h0,1,32'h0);
    vecs[10] = r(1,0,0,0,0,1,1,32'h8,0,32'h4);
    vecs[11] = r(1,0,0,0,0,1,1,32'h9,1,32'h4);
    vecs[12] = r(1,0,0,0,1,1,0,32'h0,1,32'h4);
    vecs[13] = r(1,0,0,0,0,1,1,32'h8,1,32'h4);
    vecs[14] = r(1,0,0,0,0,1,1,32'h9,1,32'h4);
    vecs[15] = r(1,0,0,0,0,1,1,32'hA,1,32'h4);
    vecs[16] = r(1,0,0,0,0,1,1,32'hB,1,32'h4);
    vecs[17] = r(1,0,0,0,0,1,0,32'h0,1,32'h4);
    vecs[18] = r(1,0,0,0,0,1,1,32'hC,0,32'h8);
    vecs[19] = r(1,1,32'h103,0,0,1,0,32'h0,1,32'h8);
    vecs[20] = r(1,0,0,0,0,1,1,32'h100,1,32'h8);
    vecs[21] = r(1,0,0,0,0,1,1,32'h101,1,32'h8);
    vecs[22] = r(1,0,0,0,0,1,1,32'h102,1,32'h8);
    vecs[23] = r(1,0,0,0,0,1,1,32'h103,1,32'h8);
    vecs[24] = r(1,0,0,0,0,1,0,32'h0,1,32'h8);
    vecs[25] = r(1,0,0,0,0,1,1,32'h104,0,32'h100);
    vecs[26] = r(1,0,0,0,0,1,1,32'h105,1,32'h100);
    vecs[27] = r(1,0,0,0,0,1,1,32'h106,1,32'h100);
    vecs[28] = r(1,0,0,1,0,1,1,32'h107,1,32'h100);
    vecs[29] = r(1,0,0,1,0,1,0,32'h0,1,32'h100);
    vecs[30] = r(1,0,0,1,0,1,0,32'h0,1,32'h100);
    vecs[31] = r(1,0,0,0,0,1,0,32'h0,1,32'h100);
    vecs[32] = r(1,0,0,0,0,1,1,32'h108,0,32'h104);
    vecs[33] = r(0,0,0,0,0,1,0,32'h0,1,32'h104);
    vecs[34] = r(1,0,0,0,0,1,1,32'h108,1,32'h104);
    vecs[35] = r(1,0,0,0,0,1,1,32'h109,1,32'h104);
    vecs[36] = r(1,0,0,0,0,1,1,32'h10A,1,32'h104);
    vecs[37] = r(1,0,0,0,0,1,1,32'h10B,1,32'h104);
    vecs[38] = r(1,0,0,0,0,1,0,32'h0,1,32'h104);
    vecs[39] = r(1,1,32'hFFFF_FFFC,0,0,1,0,32'h0,0,32'h108);
    vecs[40] = r(1,0,0,0,0,1,1,32'hFFFF_FFFC,1,32'h108);
    vecs[41] = r(1,0,0,0,0,1,1,32'hFFFF_FFFD,1,32'h108);
    vecs[42] = r(1,0,0,0,0,1,1,32'hFFFF_FFFE,1,32'h108);
    vecs[43] = r(1,0,0,0,0,1,1,32'hFFFF_FFFF,1,32'h108);
    vecs[44] = r(1,0,0,0,0,1,0,32'h0,1,32'h108);
    vecs[45] = r(1,0,0,0,0,0,0,32'h0,0,32'hFFFF_FFFC);

    repeat (3) @(negedge clk_in);
    #1;
    chk1("reset_busy", busy_out, 1'b1);
    chk32("reset_inst", if_inst, 32'h0);
    chk32("reset_pc", if_inst_pc, 32'h0);

    for (int i = 0; i < 46; i++) begin
      @(negedge clk_in);
      rst_in       = 1'b0;
      rdy_in       = vecs[i].rdy;
      br_in        = vecs[i].br;
      br_target_in = vecs[i].tgt;
      stall_in     = vecs[i].stall;
      mem_busy_in  = vecs[i].mb;
      #1;
      if (vecs[i].chk) chk1($sformatf("row%0d_rd", i), mem_rd_out, vecs[i].rd);
      if (vecs[i].chk && vecs[i].rd) chk32($sformatf("row%0d_addr", i), mem_a_out, vecs[i].a);
      chk1($sformatf("row%0d_busy", i), busy_out, vecs[i].busy);
      chk32($sformatf("row%0d_ipc", i), if_inst_pc, vecs[i].ipc);
      if (!vecs[i].busy) chk32($sformatf("row%0d_inst", i), if_inst, word_at(vecs[i].ipc));
    end
    rdy_in = 1'b1; br_in = 1'b0; stall_in = 1'b0; mem_busy_in = 1'b0;

    run_pass(1);
    run_pass(2);

    br_in = 1'b1;
    br_target_in = 32'h200;
    @(negedge clk_in);
    br_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    chk1("midrst_busy", busy_out, 1'b1);
    chk32("midrst_inst", if_inst, 32'h0);
    chk32("midrst_pc", if_inst_pc, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk32("postrst_addr", mem_a_out, 32'h0);
    chk1("postrst_rd", mem_rd_out, 1'b1);
    measure(lat);
    chk32("postrst_lat", lat, 5);
    chk32("postrst_pc", if_inst_pc, 32'h0);
    chk32("postrst_inst", if_inst, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
